// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
//   Shared types and constants for the unified-memory port arbiter.
//   - arb_state_t : arbiter FSM states (IDLE, BUSY_IF, BUSY_DM)
//   - arb_owner_t : which pipeline stage owns / last owned the memory port
//   - TMO_CYC_DEFAULT / TMO_W : default timeout length and its counter width
// ---------------------------------------------------------------------------
package mem_arb_pkg;

   localparam int unsigned TMO_CYC_DEFAULT = 32'd16;
   localparam int unsigned TMO_W           = $clog2(TMO_CYC_DEFAULT);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY_IF = 2'd1,
      BUSY_DM = 2'd2
   } arb_state_t;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_DM = 1'b1
   } arb_owner_t;

endpackage

// File: rtl/arb_timeout_ctr.sv
// ---------------------------------------------------------------------------
// arb_timeout_ctr
//   Counts busy cycles that pass without a memory response and flags the
//   cycle in which the count reaches LIMIT-1, so that the owner's timeout
//   response becomes visible LIMIT cycles after the grant.
//   Ports:
//     clk     in  system clock
//     rst     in  asynchronous active-low reset
//     clr     in  restart the count (new access granted)
//     en      in  count this cycle (busy, no response)
//     expired out this counting cycle takes the count to LIMIT-1
//   Parameter LIMIT must be >= 2.
// ---------------------------------------------------------------------------
module arb_timeout_ctr #(
   parameter int unsigned LIMIT = 32'd16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int unsigned CW   = $clog2(LIMIT);
   localparam logic [CW-1:0] LAST = CW'(LIMIT - 32'd2);

   logic [CW-1:0] count;

   // Busy-cycle counter: restarts on every grant, advances while waiting.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         count <= count + CW'(1);
      end else begin
         count <= count;
      end
   end

   // Flag the waiting cycle whose increment would reach LIMIT-1.
   assign expired = en & (count == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-port memory between instruction fetch (if_*) and the
//   data memory stage (dm_*). One access is in flight at a time; a new one
//   can be accepted while idle or in the cycle the pending response lands.
//   Grants are combinational; responses to the owner are registered.
//   Ports:
//     clk, rst                 clock, asynchronous active-low reset
//     if_req/if_addr           fetch read request
//     if_gnt                   fetch accepted this cycle
//     if_rvalid/if_rdata       fetch response pulse and data
//     dm_req/dm_we/dm_addr/dm_wdata  data load/store request
//     dm_gnt                   data request accepted this cycle
//     dm_rvalid/dm_rdata       data response pulse (rdata 0 for stores)
//     mem_req/mem_we/mem_addr/mem_wdata  memory command (1 cycle per access)
//     mem_rvalid/mem_rdata     memory response
//     tmo_err                  sticky timeout flag, cleared only by reset
//   Configuration:
//     ARB_RR_EN  defined  : round-robin between the two requesters
//                undefined: data stage always wins a collision
// ---------------------------------------------------------------------------
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned AW      = 32'd32,
   parameter int unsigned DW      = 32'd32,
   parameter int unsigned TMO_CYC = mem_arb_pkg::TMO_CYC_DEFAULT
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_gnt,
   output logic          if_rvalid,
   output logic [DW-1:0] if_rdata,
   input  logic          dm_req,
   input  logic          dm_we,
   input  logic [AW-1:0] dm_addr,
   input  logic [DW-1:0] dm_wdata,
   output logic          dm_gnt,
   output logic          dm_rvalid,
   output logic [DW-1:0] dm_rdata,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic          mem_rvalid,
   input  logic [DW-1:0] mem_rdata,
   output logic          tmo_err
);

   arb_state_t state;
   logic       pendingStore;
   logic       canAccept;
   logic       pickDm;
   logic       ifGrant;
   logic       dmGrant;
   logic       busy;
   logic       timerEn;
   logic       timedOut;

`ifdef ARB_RR_EN
   arb_owner_t lastOwner;
`endif

   assign busy    = (state == BUSY_IF) || (state == BUSY_DM);
   assign timerEn = busy & ~mem_rvalid;

   // Acceptance window and requester selection.
   always_comb begin
      canAccept = 1'b0;
      pickDm    = 1'b0;
      case (state)
         IDLE:    canAccept = 1'b1;
         BUSY_IF: canAccept = mem_rvalid;
         BUSY_DM: canAccept = mem_rvalid;
         default: canAccept = 1'b0;
      endcase
`ifdef ARB_RR_EN
      // On a collision the stage that did not go last wins.
      if (if_req && dm_req) begin
         pickDm = (lastOwner == OWN_IF);
      end else begin
         pickDm = dm_req;
      end
`else
      // The older instruction in M always goes first.
      pickDm = dm_req;
`endif
      dmGrant = canAccept & dm_req & pickDm;
      ifGrant = canAccept & if_req & ~dmGrant;
   end

   assign if_gnt = ifGrant;
   assign dm_gnt = dmGrant;

   // Memory command mux; idle bus is driven to zero.
   always_comb begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (dmGrant) begin
         mem_req   = 1'b1;
         mem_we    = dm_we;
         mem_addr  = dm_addr;
         mem_wdata = dm_wdata;
      end else if (ifGrant) begin
         mem_req   = 1'b1;
         mem_we    = 1'b0;
         mem_addr  = if_addr;
         mem_wdata = '0;
      end else begin
         mem_req   = 1'b0;
         mem_we    = 1'b0;
         mem_addr  = '0;
         mem_wdata = '0;
      end
   end

   arb_timeout_ctr #(
      .LIMIT (TMO_CYC)
   ) uTimeout (
      .clk     (clk),
      .rst     (rst),
      .clr     (ifGrant | dmGrant),
      .en      (timerEn),
      .expired (timedOut)
   );

   // Arbiter FSM with registered owner responses and sticky timeout flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         pendingStore <= 1'b0;
         if_rvalid    <= 1'b0;
         if_rdata     <= '0;
         dm_rvalid    <= 1'b0;
         dm_rdata     <= '0;
         tmo_err      <= 1'b0;
      end else begin
         if_rvalid <= 1'b0;
         dm_rvalid <= 1'b0;

         // Route the response (or a zero-data timeout response) to the owner.
         case (state)
            BUSY_IF: begin
               if (mem_rvalid) begin
                  if_rvalid <= 1'b1;
                  if_rdata  <= mem_rdata;
               end else if (timedOut) begin
                  if_rvalid <= 1'b1;
                  if_rdata  <= '0;
                  tmo_err   <= 1'b1;
               end
            end
            BUSY_DM: begin
               if (mem_rvalid) begin
                  dm_rvalid <= 1'b1;
                  dm_rdata  <= pendingStore ? '0 : mem_rdata;
               end else if (timedOut) begin
                  dm_rvalid <= 1'b1;
                  dm_rdata  <= '0;
                  tmo_err   <= 1'b1;
               end
            end
            default: begin
               // IDLE (or an unreachable code): responses are ignored here.
            end
         endcase

         // Next state: a same-cycle grant takes precedence over going idle.
         if (dmGrant) begin
            state        <= BUSY_DM;
            pendingStore <= dm_we;
         end else if (ifGrant) begin
            state        <= BUSY_IF;
            pendingStore <= 1'b0;
         end else if (!busy || mem_rvalid || timedOut) begin
            state        <= IDLE;
         end
      end
   end

`ifdef ARB_RR_EN
   // Remember who was granted last for the round-robin decision.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lastOwner <= OWN_IF;
      end else if (dmGrant) begin
         lastOwner <= OWN_DM;
      end else if (ifGrant) begin
         lastOwner <= OWN_IF;
      end else begin
         lastOwner <= lastOwner;
      end
   end
`endif

endmodule
